// File: rtl/dmem_store_buffer_if.sv
// rtl/dmem_store_buffer_if.sv - store/load/memory-port bundle for dmem_store_buffer
interface dmem_store_buffer_if #(
    parameter int DMEMADDRBITS = 11,
    parameter int DBITS        = 32,
    parameter int CNTBITS      = 3
);
    logic                    st_valid;
    logic [DMEMADDRBITS-1:0] st_addr;
    logic [DBITS-1:0]        st_data;
    logic                    st_ready;
    logic                    ld_valid;
    logic [DMEMADDRBITS-1:0] ld_addr;
    logic                    ld_hit;
    logic [DBITS-1:0]        ld_data;
    logic                    mem_wrtEn;
    logic [DMEMADDRBITS-1:0] mem_addr;
    logic [DBITS-1:0]        mem_in;
    logic                    empty;
    logic [CNTBITS-1:0]      count;

    // memory stage side
    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, ld_hit, ld_data, mem_wrtEn, mem_addr, mem_in, empty, count
    );

    // store buffer side
    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, ld_hit, ld_data, mem_wrtEn, mem_addr, mem_in, empty, count
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-write store buffer with load forwarding (optional STBUF_COALESCE_EN)
module dmem_store_buffer #(
    parameter int DMEMADDRBITS = 11,
    parameter int DBITS        = 32,
    parameter int DEPTH        = 4,
    parameter int CNTBITS      = 3
) (
    input logic                 clk,
    input logic                 reset,
    dmem_store_buffer_if.slave  bus
);
    localparam int PTRBITS = $clog2(DEPTH);

    logic [DMEMADDRBITS-1:0] addr_q [DEPTH];
    logic [DBITS-1:0]        data_q [DEPTH];
    logic [PTRBITS-1:0]      hp_q, hp_d, tp_q, tp_d;
    logic [CNTBITS-1:0]      count_q, count_d;

    logic                    pop, push, coalesce, st_ready;
    logic [PTRBITS-1:0]      young_idx;
    logic                    ld_hit;
    logic [DBITS-1:0]        ld_data;
    logic [PTRBITS-1:0]      fwd_idx;
    logic                    mem_wrtEn;
    logic [DMEMADDRBITS-1:0] mem_addr;
    logic [DBITS-1:0]        mem_in;

    assign young_idx = tp_q - PTRBITS'(1);

    // Port arbitration, acceptance and pointer/occupancy next state
    always_comb begin
        pop      = !bus.ld_valid && (count_q != '0);
        coalesce = 1'b0;
`ifdef STBUF_COALESCE_EN
        // Merge into the youngest entry unless it is the head leaving this cycle
        coalesce = bus.st_valid && (count_q != '0) &&
                   (addr_q[young_idx] == bus.st_addr) &&
                   !(pop && (count_q == CNTBITS'(1)));
`endif
        st_ready = (count_q < CNTBITS'(DEPTH)) || coalesce;
        push     = bus.st_valid && st_ready && !coalesce;
        hp_d     = pop  ? hp_q + PTRBITS'(1) : hp_q;
        tp_d     = push ? tp_q + PTRBITS'(1) : tp_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNTBITS'(1);
            2'b01:   count_d = count_q - CNTBITS'(1);
            default: count_d = count_q;
        endcase
    end

    // Memory port mux: loads win, otherwise drain the head entry
    always_comb begin
        mem_wrtEn = 1'b0;
        mem_addr  = '0;
        mem_in    = '0;
        if (bus.ld_valid) begin
            mem_addr = bus.ld_addr;
            mem_in   = data_q[hp_q];
        end else if (count_q != '0) begin
            mem_wrtEn = 1'b1;
            mem_addr  = addr_q[hp_q];
            mem_in    = data_q[hp_q];
        end
    end

    // Forwarding: walk oldest to youngest so the youngest match wins
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = hp_q + PTRBITS'(k);
            if ((CNTBITS'(k) < count_q) && (addr_q[fwd_idx] == bus.ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[fwd_idx];
            end
        end
    end

    // Pointer and occupancy registers; reset discards pending stores
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hp_q    <= '0;
            tp_q    <= '0;
            count_q <= '0;
        end else begin
            hp_q    <= hp_d;
            tp_q    <= tp_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between hp and tp
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tp_q] <= bus.st_addr;
            data_q[tp_q] <= bus.st_data;
        end else if (coalesce) begin
            data_q[young_idx] <= bus.st_data;
        end
    end

    assign bus.st_ready  = st_ready;
    assign bus.ld_hit    = ld_hit;
    assign bus.ld_data   = ld_data;
    assign bus.mem_wrtEn = mem_wrtEn;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_in    = mem_in;
    assign bus.empty     = (count_q == '0);
    assign bus.count     = count_q;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - self-checking bench for dmem_store_buffer
module tb_dmem_store_buffer;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CB    = 3;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    ent_t q[$];
    logic [AW-1:0] exp_q[$];

    always #5 clk = ~clk;

    dmem_store_buffer_if #(.DMEMADDRBITS(AW), .DBITS(DW), .CNTBITS(CB)) bus ();

    dmem_store_buffer #(.DMEMADDRBITS(AW), .DBITS(DW), .DEPTH(DEPTH), .CNTBITS(CB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic drive(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                         input logic lv, input logic [AW-1:0] la);
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        drive(1'b0, '0, '0, 1'b0, '0);
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.st_ready, bus.empty, bus.count, bus.mem_wrtEn, bus.mem_addr, bus.mem_in, bus.ld_hit, bus.ld_data}
            !== {1'b1, 1'b1, 3'd0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b0, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b empty=%b cnt=%0d wen=%b", bus.st_ready, bus.empty, bus.count, bus.mem_wrtEn);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, AW'(11'h040 + i), DW'(32'h5000 + i), 1'b1, 11'h7FF);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0);
        #2;
        vectors++;
        if (bus.count !== 3'd3 || bus.mem_wrtEn !== 1'b1 || bus.mem_addr !== 11'h040) begin
            errors++;
            $display("FAIL reset_predrain: got cnt=%0d wen=%b addr=%h need 3 1 040", bus.count, bus.mem_wrtEn, bus.mem_addr);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.count, bus.empty, bus.mem_wrtEn, bus.mem_addr, bus.mem_in, bus.st_ready}
            !== {3'd0, 1'b1, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL reset_middrain: got cnt=%0d empty=%b wen=%b addr=%h", bus.count, bus.empty, bus.mem_wrtEn, bus.mem_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            vectors++;
            if (bus.mem_wrtEn !== 1'b0 || bus.empty !== 1'b1) begin
                errors++;
                $display("FAIL reset_nowrite: cycle %0d got wen=%b empty=%b need 0 1", i, bus.mem_wrtEn, bus.empty);
            end
        end
    endtask

    task automatic test_single_drain();
        do_reset();
        @(negedge clk);
        drive(1'b1, 11'h010, 32'hAAAA_0001, 1'b0, '0);
        #2;
        vectors++;
        if (bus.mem_wrtEn !== 1'b0 || bus.st_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_push: got wen=%b rdy=%b need 0 1", bus.mem_wrtEn, bus.st_ready);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0);
        #2;
        vectors++;
        if ({bus.mem_wrtEn, bus.mem_addr, bus.mem_in, bus.count} !== {1'b1, 11'h010, 32'hAAAA_0001, 3'd1}) begin
            errors++;
            $display("FAIL single_write: got wen=%b addr=%h data=%h cnt=%0d", bus.mem_wrtEn, bus.mem_addr, bus.mem_in, bus.count);
        end
        @(negedge clk);
        #2;
        vectors++;
        if (bus.mem_wrtEn !== 1'b0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL single_after: got wen=%b empty=%b need 0 1", bus.mem_wrtEn, bus.empty);
        end
    endtask

    task automatic test_fill_stall();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            drive(1'b1, AW'(11'h100 + i), DW'(32'h1000 + i), 1'b1, 11'h7FF);
            #2;
            vectors++;
            if (bus.count !== CB'(i) || bus.st_ready !== 1'b1 || bus.mem_wrtEn !== 1'b0) begin
                errors++;
                $display("FAIL fill_push%0d: got cnt=%0d rdy=%b wen=%b", i, bus.count, bus.st_ready, bus.mem_wrtEn);
            end
        end
        @(negedge clk);
        drive(1'b1, 11'h104, 32'h1004, 1'b1, 11'h7FF);
        @(negedge clk);
        #2;
        vectors++;
        if (bus.count !== 3'd4 || bus.st_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b need 4 0", bus.count, bus.st_ready);
        end
        @(negedge clk);
        drive(1'b1, 11'h104, 32'h1004, 1'b0, '0);
        #2;
        vectors++;
        if ({bus.st_ready, bus.mem_wrtEn, bus.mem_addr, bus.mem_in} !== {1'b0, 1'b1, 11'h100, 32'h1000}) begin
            errors++;
            $display("FAIL fill_release: got rdy=%b wen=%b addr=%h data=%h", bus.st_ready, bus.mem_wrtEn, bus.mem_addr, bus.mem_in);
        end
        @(negedge clk);
        #2;
        vectors++;
        if ({bus.st_ready, bus.count, bus.mem_addr} !== {1'b1, 3'd3, 11'h101}) begin
            errors++;
            $display("FAIL fill_reopen: got rdy=%b cnt=%0d addr=%h need 1 3 101", bus.st_ready, bus.count, bus.mem_addr);
        end
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            drive(1'b0, '0, '0, 1'b0, '0);
            #2;
            vectors++;
            if ({bus.mem_wrtEn, bus.mem_addr, bus.mem_in} !== {1'b1, AW'(11'h100 + i), DW'(32'h1000 + i)}) begin
                errors++;
                $display("FAIL fill_order%0d: got wen=%b addr=%h data=%h", i, bus.mem_wrtEn, bus.mem_addr, bus.mem_in);
            end
        end
        @(negedge clk);
        #2;
        vectors++;
        if (bus.empty !== 1'b1 || bus.mem_wrtEn !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty: got empty=%b wen=%b need 1 0", bus.empty, bus.mem_wrtEn);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        @(negedge clk);
        drive(1'b1, 11'h020, 32'd1, 1'b1, 11'h7FF);
        @(negedge clk);
        drive(1'b1, 11'h020, 32'd2, 1'b1, 11'h7FF);
        @(negedge clk);
        drive(1'b1, 11'h020, 32'd3, 1'b1, 11'h020);
        #2;
        vectors++;
        if ({bus.ld_hit, bus.ld_data, bus.mem_wrtEn, bus.mem_addr} !== {1'b1, 32'd2, 1'b0, 11'h020}) begin
            errors++;
            $display("FAIL fwd_youngest: got hit=%b data=%h wen=%b addr=%h need 1 2 0 020", bus.ld_hit, bus.ld_data, bus.mem_wrtEn, bus.mem_addr);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b1, 11'h020);
        #2;
        vectors++;
        if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'd3) begin
            errors++;
            $display("FAIL fwd_after_push: got hit=%b data=%h need 1 3", bus.ld_hit, bus.ld_data);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b1, 11'h021);
        #2;
        vectors++;
        if ({bus.ld_hit, bus.ld_data, bus.mem_wrtEn, bus.mem_addr} !== {1'b0, 32'd0, 1'b0, 11'h021}) begin
            errors++;
            $display("FAIL fwd_miss: got hit=%b data=%h wen=%b addr=%h need 0 0 0 021", bus.ld_hit, bus.ld_data, bus.mem_wrtEn, bus.mem_addr);
        end
    endtask

    task automatic test_push_pop_wrap();
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, AW'(11'h1F0 + i), DW'(32'hF0 + i), 1'b1, 11'h7FF);
            exp_q.push_back(AW'(11'h1F0 + i));
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(1'b1, AW'(11'h200 + k), DW'(k), 1'b0, '0);
            #2;
            vectors++;
            if ({bus.count, bus.mem_wrtEn, bus.st_ready, bus.mem_addr} !== {3'd2, 1'b1, 1'b1, exp_q[0]}) begin
                errors++;
                $display("FAIL wrap_cycle%0d: got cnt=%0d wen=%b rdy=%b addr=%h need 2 1 1 %h",
                         k, bus.count, bus.mem_wrtEn, bus.st_ready, bus.mem_addr, exp_q[0]);
            end
            void'(exp_q.pop_front());
            exp_q.push_back(AW'(11'h200 + k));
        end
    endtask

    task automatic test_coalesce_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            drive(1'b1, AW'(11'h031 + i) & (i == DEPTH - 1 ? 11'h030 : 11'h7FF), DW'(32'h300 + i), 1'b1, 11'h7FF);
        end
        @(negedge clk);
        drive(1'b1, 11'h030, 32'd7, 1'b1, 11'h7FF);
        #2;
`ifdef STBUF_COALESCE_EN
        vectors++;
        if (bus.st_ready !== 1'b1 || bus.count !== 3'd4) begin
            errors++;
            $display("FAIL coal_accept: got rdy=%b cnt=%0d need 1 4", bus.st_ready, bus.count);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b1, 11'h030);
        #2;
        vectors++;
        if (bus.count !== 3'd4 || bus.ld_data !== 32'd7) begin
            errors++;
            $display("FAIL coal_merge: got cnt=%0d data=%h need 4 7", bus.count, bus.ld_data);
        end
`else
        vectors++;
        if (bus.st_ready !== 1'b0 || bus.count !== 3'd4) begin
            errors++;
            $display("FAIL full_same_addr: got rdy=%b cnt=%0d need 0 4", bus.st_ready, bus.count);
        end
`endif
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) @(negedge clk);
            #2;
            if (i == DEPTH - 1) begin
                vectors++;
`ifdef STBUF_COALESCE_EN
                if ({bus.mem_wrtEn, bus.mem_addr, bus.mem_in} !== {1'b1, 11'h030, 32'd7}) begin
`else
                if ({bus.mem_wrtEn, bus.mem_addr, bus.mem_in} !== {1'b1, 11'h030, 32'h303}) begin
`endif
                    errors++;
                    $display("FAIL coal_written: got wen=%b addr=%h data=%h", bus.mem_wrtEn, bus.mem_addr, bus.mem_in);
                end
            end
        end
    endtask

    task automatic test_random();
        logic          sv, lv, e_pop, e_co, e_ready, e_hit, e_wen, min_known;
        logic [AW-1:0] sa, la, e_maddr;
        logic [DW-1:0] sd, e_ld, e_min;
        int            sz;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            sv = ($urandom_range(0, 9) < 6);
            lv = ($urandom_range(0, 9) < 4);
            sa = AW'($urandom_range(0, 7));
            la = AW'($urandom_range(0, 7));
            sd = $urandom;
            drive(sv, sa, sd, lv, la);
            #2;
            sz      = q.size();
            e_pop   = !lv && (sz > 0);
            e_co    = 1'b0;
`ifdef STBUF_COALESCE_EN
            e_co    = sv && (sz > 0) && (q[sz-1].a == sa) && !(e_pop && sz == 1);
`endif
            e_ready = (sz < DEPTH) || e_co;
            e_hit   = 1'b0;
            e_ld    = '0;
            foreach (q[i]) if (q[i].a == la) begin e_hit = 1'b1; e_ld = q[i].d; end
            min_known = 1'b1;
            e_min     = '0;
            e_maddr   = '0;
            e_wen     = 1'b0;
            if (lv) begin
                e_maddr   = la;
                min_known = (sz > 0);
                if (sz > 0) e_min = q[0].d;
            end else if (sz > 0) begin
                e_wen   = 1'b1;
                e_maddr = q[0].a;
                e_min   = q[0].d;
            end
            vectors++;
            if ({bus.st_ready, bus.count, bus.empty, bus.ld_hit, bus.ld_data, bus.mem_wrtEn, bus.mem_addr}
                !== {e_ready, CB'(sz), (sz == 0), e_hit, e_ld, e_wen, e_maddr}) begin
                errors++;
                $display("FAIL rand%0d: got rdy=%b cnt=%0d hit=%b ld=%h wen=%b addr=%h need %b %0d %b %h %b %h",
                         n, bus.st_ready, bus.count, bus.ld_hit, bus.ld_data, bus.mem_wrtEn, bus.mem_addr,
                         e_ready, sz, e_hit, e_ld, e_wen, e_maddr);
            end
            if (min_known) begin
                vectors++;
                if (bus.mem_in !== e_min) begin
                    errors++;
                    $display("FAIL rand_memin%0d: got %h need %h", n, bus.mem_in, e_min);
                end
            end
            if (e_pop) void'(q.pop_front());
            if (e_co) q[q.size()-1].d = sd;
            else if (sv && e_ready) q.push_back({sa, sd});
        end
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, '0);
        test_reset();
        test_single_drain();
        test_fill_stall();
        test_forwarding();
        test_push_pop_wrap();
        test_coalesce_full();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Posted-write buffer between the processor memory stage and the data-memory controller. Stores are queued in a small in-order FIFO and drained one per cycle into the controller's single port. Loads get priority on that port and are forwarded from the buffer when they hit a pending store, so the pipeline never stalls on a store unless the buffer is full.

## Interface
- DMEMADDRBITS, 11: word-address width presented to the data memory.
- DBITS, 32: data word width.
- DEPTH, 4: number of buffer entries; power of two, ≥2.
- CNTBITS, 3: width of `count`; must hold DEPTH (log2(DEPTH)+1).
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- st_valid  in  1  memory stage presents a store this cycle.
- st_addr  in  DMEMADDRBITS  store word address.
- st_data  in  DBITS  store data.
- st_ready  out  1  store accepted at this posedge when st_valid && st_ready.
- ld_valid  in  1  memory stage presents a load this cycle.
- ld_addr  in  DMEMADDRBITS  load word address.
- ld_hit  out  1  load address matches a pending entry (combinational).
- ld_data  out  DBITS  youngest matching entry's data; 0 when !ld_hit.
- mem_wrtEn  out  1  write enable to data memory.
- mem_addr  out  DMEMADDRBITS  address to data memory.
- mem_in  out  DBITS  write data to data memory.
- empty  out  1  no pending entries.
- count  out  CNTBITS  number of pending entries.

## Operation
- Storage: DEPTH entries of {addr, data}, head pointer `hp`, tail pointer `tp` (log2(DEPTH) bits, wrap modulo DEPTH), occupancy `count`.
- st_ready = (count < DEPTH). Push at posedge when st_valid && st_ready: entry[tp] ← {st_addr, st_data}, tp++.
- Port arbitration (combinational from state and ld_*):
  - ld_valid=1: mem_addr=ld_addr, mem_wrtEn=0, mem_in=entry[hp].data; no drain this cycle.
  - ld_valid=0, count>0: mem_addr=entry[hp].addr, mem_in=entry[hp].data, mem_wrtEn=1; pop at posedge (hp++).
  - ld_valid=0, count=0: mem_addr=0, mem_in=0, mem_wrtEn=0.
- Simultaneous push and pop: count unchanged, both pointers advance. Push+pop at count=DEPTH impossible (st_ready=0); push at count=0 with no pop → count=1.
- Forwarding: ld_hit = OR over valid entries of (addr == ld_addr); ld_data from youngest (closest to tail) match. A store being pushed in the same cycle is not forwarded.
- Ordering: stores reach memory in issue order; a load with !ld_hit reads memory, which already holds every older drained store.
- Reset (reset=0, any time incl. mid-drain): hp=tp=count=0; pending stores discarded. Outputs: st_ready=1, empty=1, count=0, mem_wrtEn=0, mem_addr=0, mem_in=0, ld_hit=0, ld_data=0 (while ld_valid=0).

## Timing
- Store-to-memory latency: pushed at posedge N, earliest mem_wrtEn cycle is N→N+1 (written by the controller's negedge in that cycle); popped at posedge N+1.
- All mem_* outputs settle within the first half-cycle; the controller samples on negedge.
- Load forwarding is zero-cycle; ld_data valid the same cycle as ld_valid.
- Continuous ld_valid starves drain; st_ready deasserts when full, pipeline stalls.

## Configuration
- STBUF_COALESCE_EN defined: a store whose st_addr equals the youngest entry's address, while that entry is not the head being popped this cycle, overwrites that entry's data; no allocation, tp/count unchanged, accepted even when count=DEPTH (st_ready=1 in that case).
- Not defined: every accepted store allocates a new entry; st_ready is strictly count<DEPTH.

## Test plan
- Reset mid-drain: push 3 stores, assert reset low for 1 cycle → count=0, empty=1, mem_wrtEn=0 immediately; no further writes.
- Push 0x010←0xAAAA_0001, then idle → mem_wrtEn=1, mem_addr=0x010, mem_in=0xAAAA_0001 for exactly one cycle, then empty=1.
- Fill 4 stores with ld_valid=1 held → count=4, st_ready=0, 5th store held; release ld_valid → drains in order, st_ready=1 after first pop.
- Stores 0x020←1, 0x020←2 pending, load 0x020 → ld_hit=1, ld_data=2; load 0x021 → ld_hit=0, ld_data=0, mem_addr=0x021.
- Simultaneous push/pop at count=2 → count stays 2, pointers wrap past DEPTH-1 correctly over 10 cycles.
- STBUF_COALESCE_EN: full buffer, youngest addr 0x030, store 0x030←7 with ld_valid=1 → accepted, count=4, later written value 7.
